// File: rtl/dvsd_pkg.sv
// Shared definitions for the sum collector.
// Contents:
//   state_e    - collector FSM states (ACCUM gathers operands, HOLD presents a total)
//   SUM_W      - width of the upstream adder sum field
//   OPND_W     - width of one operand, i.e. {carry-out, sum}
//   opnd_value - packs carry-out and sum into one unsigned operand
package dvsd_pkg;

    localparam int SUM_W  = 12;
    localparam int OPND_W = 13;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Carry-out is the MSB of the unsigned operand.
    function automatic logic [OPND_W-1:0] opnd_value(input logic cout, input logic [SUM_W-1:0] sum);
        return {cout, sum};
    endfunction

endpackage

// File: rtl/dvsd_sum_collector.sv
// Frame sum collector.
// It accumulates N_OPS unsigned 13-bit adder results ({in_cout,in_sum}) into
// one ACC_W-bit total. It then holds that total, with a sticky overflow flag,
// until the downstream side takes it.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake; in_sum/in_cout carry the operand
//   out_valid/out_ready - total handshake
//   out_total/out_ovf   - frame total modulo 2^ACC_W and its overflow flag
// All outputs come straight from flops.
module dvsd_sum_collector
    import dvsd_pkg::*;
#(
    parameter int N_OPS = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf
);

    localparam logic [7:0] LAST_CNT = 8'(N_OPS - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_total_q, out_total_d;
    logic               out_ovf_q, out_ovf_d;

    logic               xfer_in_s;
    logic               xfer_out_s;
    logic [ACC_W:0]     opnd_ext_s;
    logic [ACC_W:0]     sum_s;

    // The handshakes use the registered ready/valid, so no input reaches an output combinationally.
    assign xfer_in_s  = in_valid & in_ready_q;
    assign xfer_out_s = out_valid_q & out_ready;

    // The extra MSB of the (ACC_W+1)-bit add is the carry past 2^ACC_W-1.
    assign opnd_ext_s = {{(ACC_W + 1 - OPND_W){1'b0}}, opnd_value(in_cout, in_sum)};
    assign sum_s      = {1'b0, acc_q} + opnd_ext_s;

    // FSM next state and datapath next values.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (xfer_in_s) begin
                    acc_d = sum_s[ACC_W-1:0];
                    ovf_d = ovf_q | sum_s[ACC_W];
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (xfer_out_s) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = 8'd0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = ACCUM;
                acc_d   = '0;
                cnt_d   = 8'd0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Output flops are loaded from the next state, so they change on the same edge as the FSM.
    // out_total and out_ovf read as zero outside HOLD.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_total_d = '0;
        out_ovf_d   = 1'b0;
        if (state_d == HOLD) begin
            out_valid_d = 1'b1;
            out_total_d = acc_d;
            out_ovf_d   = ovf_d;
        end else begin
            in_ready_d  = 1'b1;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= 8'd0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_total_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_total_q <= out_total_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_total = out_total_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: doc/dvsd_sum_collector.md
DVSD_SUM_COLLECTOR -- requirements
Module: dvsd_sum_collector

Interface
REQ-001 Parameter N_OPS, default 4, sets the number of adder results summed per frame; legal range 1..255.
REQ-002 Parameter ACC_W, default 16, sets the accumulator and total width; legal range 13..32.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_valid  input  1  the upstream 12-bit adder result is presented.
REQ-006 Port in_ready  output  1  the block accepts a result this cycle.
REQ-007 Port in_sum  input  12  the adder sum S.
REQ-008 Port in_cout  input  1  the adder carry-out; the operand value is {in_cout,in_sum}, 13 bits, unsigned.
REQ-009 Port out_valid  output  1  the frame total is available.
REQ-010 Port out_ready  input  1  the downstream consumer takes the total.
REQ-011 Port out_total  output  ACC_W  the frame sum modulo 2^ACC_W.
REQ-012 Port out_ovf  output  1  the frame sum exceeded 2^ACC_W-1.

Function
REQ-013 A transfer in SHALL occur on a cycle with in_valid=1 and in_ready=1; a transfer out SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-014 The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 In ACCUM, each transfer in SHALL add the zero-extended 13-bit value to acc, wrapping modulo 2^ACC_W, and SHALL increment cnt.
REQ-016 An add whose true sum exceeds 2^ACC_W-1 SHALL set the sticky ovf flag for the current frame.
REQ-017 A transfer in with cnt=N_OPS-1 SHALL move ACCUM->HOLD, so out_valid rises the cycle after the last accepted operand and out_total includes that operand.
REQ-018 In HOLD, out_total and out_ovf SHALL stay stable until the transfer out.
REQ-019 A transfer out SHALL clear acc, cnt and ovf, move HOLD->ACCUM, and raise in_ready on the next cycle.
REQ-020 Cycles with in_valid=0 in ACCUM SHALL leave acc, cnt and ovf unchanged (bubbles allowed).
REQ-021 in_sum and in_cout SHALL be ignored whenever no transfer in occurs.
REQ-022 With N_OPS=1, every transfer in SHALL go directly to HOLD.
REQ-023 Minimum frame period is N_OPS+1 cycles with in_valid and out_ready held high.
REQ-024 out_total and out_ovf SHALL read as zero whenever out_valid=0.
REQ-025 Every output SHALL be driven from registers, with no combinational path from any input to any output.

Reset
REQ-026 rst=1 SHALL force state ACCUM, acc=0, cnt=0 and ovf=0; out_valid=0, out_total=0, out_ovf=0 and in_ready=0 during the reset cycle.
REQ-027 rst takes priority over any concurrent transfer in or transfer out.
REQ-028 rst asserted mid-frame or in HOLD SHALL discard the partial or pending total.
REQ-029 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-030 The state enumeration (ACCUM, HOLD) and the operand width constant (OPND_W=13) SHALL reside in shared package dvsd_pkg.
REQ-031 The block SHALL be a single flat module with no sub-module; the accumulator add SHALL be a plain ACC_W+1-bit addition.

Verification
REQ-032 Default parameters; operands {0,0x005},{0,0x00A},{1,0x000},{0,0xFFF} back-to-back -> out_valid 1 cycle after the 4th accept, out_total=0x200E, out_ovf=0.
REQ-033 Default parameters; bubbles between operands and out_ready=0 for 5 cycles in HOLD -> same total held stable, in_ready=0 throughout HOLD, new frame starts only after the handshake.
REQ-034 N_OPS=16, ACC_W=16; 16 operands of {1,0xFFF}=8191 -> out_total=0xFFF0 (131056 mod 65536), out_ovf=1; the next frame starts with ovf cleared.
REQ-035 Default parameters; rst pulsed after 2 operands accepted, then 4 operands of 1 -> out_total=4, out_ovf=0.
REQ-036 N_OPS=1; continuous in_valid with out_ready=1 -> one result every 2 cycles, each out_total equal to its single operand.
